// File: rtl/sha2_padder_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : sha2_padder_multi_if
// Description : AXI4-Stream style bundle used on both sides of the SHA-2
//               padder. tdata/tkeep/tvalid/tlast travel from master to
//               slave; tready travels back.
//               Modports: master (drives data), slave (drives tready).
// Revision    : 1.0 - initial release
// ============================================================================
interface sha2_padder_multi_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tkeep, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/sha2_padder_multi.sv
`default_nettype none
// ============================================================================
// Module      : sha2_padder_multi
// Description : SHA-2 message padder. Repacks input beats into big-endian
//               512-bit (sha_type=0) or 1024-bit (sha_type=1) blocks, adds
//               the 0x80 marker, zero fill and the bit-length field, and
//               emits an extra block when the length does not fit.
// Ports       : axis_aclk  - clock (rising edge)
//               axis_reset - synchronous active-high reset
//               sha_type   - block size select, latched per message
//               en         - permits the start of a new message
//               s_axis     - input beats (slave modport, S_DATA_WIDTH)
//               m_axis     - output blocks (master modport, 1024 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sha2_padder_multi #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 1024,
    parameter int LEN_WIDTH    = 64
) (
    input  wire logic           axis_aclk,
    input  wire logic           axis_reset,
    input  wire logic           sha_type,
    input  wire logic           en,
    sha2_padder_multi_if.slave  s_axis,
    sha2_padder_multi_if.master m_axis
);
    localparam int c_SB = S_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_EMIT_DATA  = 3'd2,
        ST_PAD_FULL   = 3'd3,
        ST_PAD_LEN    = 3'd4,
        ST_EMIT_FINAL = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  r_after;     // where to go once the data block is taken
    logic                    r_mode;
    logic [7:0]              r_ptr;
    logic [LEN_WIDTH-1:0]    r_count;
    logic [M_DATA_WIDTH-1:0] r_buf;
    logic                    r_m_valid;
    logic                    r_m_last;

    logic                    w_accept;
    logic                    w_mode;
    logic [7:0]              w_base;
    logic [7:0]              w_kept;
    logic [7:0]              w_fill;
    logic [7:0]              w_ptr_next;
    logic [7:0]              w_bw;
    logic [7:0]              w_lim;
    logic [LEN_WIDTH-1:0]    w_cnt_base;
    logic [LEN_WIDTH-1:0]    w_cnt_new;
    logic [63:0]             w_len_bits;
    logic [63:0]             w_len_reg;
    logic [M_DATA_WIDTH-1:0] w_buf_data;
    logic [M_DATA_WIDTH-1:0] w_buf_mark;
    logic [M_DATA_WIDTH-1:0] w_buf_len;
    logic [M_DATA_WIDTH-1:0] w_pad_full;
    logic [M_DATA_WIDTH-1:0] w_pad_len;

    // Ready is held low during reset so the reset-state value is 0.
    assign s_axis.tready = ~axis_reset & ((r_state == ST_FILL) | ((r_state == ST_IDLE) & en));
    assign w_accept      = s_axis.tvalid & s_axis.tready;

    assign m_axis.tdata  = r_buf;
    assign m_axis.tkeep  = '1;
    assign m_axis.tvalid = r_m_valid;
    assign m_axis.tlast  = r_m_last;

    // The length field always ends at bit 0; in 1024 mode its upper 64 bits
    // are the already-zero bits [127:64].
    assign w_len_reg = 64'(r_count) << 3;

    always_comb begin
        int top;
        int pos;
        // The first beat of a message is handled from IDLE as if in FILL with
        // ptr = 0 and count = 0, and the live sha_type is the one that sticks.
        w_mode     = (r_state == ST_IDLE) ? sha_type : r_mode;
        w_base     = (r_state == ST_IDLE) ? 8'd0 : r_ptr;
        w_cnt_base = (r_state == ST_IDLE) ? '0 : r_count;
        w_bw       = w_mode ? 8'd128 : 8'd64;
        w_lim      = w_mode ? 8'd111 : 8'd55;   // last byte that still leaves room for the length
        top        = w_mode ? 1023 : 511;

        // Kept count = index of the first zero in tkeep (last beat only).
        w_kept = 8'(c_SB);
        if (s_axis.tlast) begin
            for (int i = c_SB - 1; i >= 0; i--) begin
                if (!s_axis.tkeep[i]) w_kept = 8'(i);
            end
        end
        w_fill     = w_base + w_kept;
        w_ptr_next = w_base + 8'(c_SB);
        w_cnt_new  = w_cnt_base + LEN_WIDTH'(w_kept);
        w_len_bits = 64'(w_cnt_new) << 3;

        w_buf_data = r_buf;
        for (int k = 0; k < c_SB; k++) begin
            pos = int'(w_base) + k;
            if (k < int'(w_kept) && pos < int'(w_bw)) begin
                w_buf_data[top - 8*pos -: 8] = s_axis.tdata[8*k +: 8];
            end
        end

        w_buf_mark = w_buf_data;
        if (w_fill < w_bw) begin
            w_buf_mark[top - 8*int'(w_fill) -: 8] = 8'h80;
        end
        w_buf_len        = w_buf_mark;
        w_buf_len[63:0]  = w_len_bits;

        w_pad_full       = '0;
        w_pad_full[(r_mode ? 1023 : 511) -: 8] = 8'h80;
        w_pad_full[63:0] = w_len_reg;
        w_pad_len        = '0;
        w_pad_len[63:0]  = w_len_reg;
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state   <= ST_IDLE;
            r_after   <= ST_FILL;
            r_mode    <= 1'b0;
            r_ptr     <= 8'd0;
            r_count   <= '0;
            r_buf     <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    if (w_accept) begin
                        r_mode  <= w_mode;
                        r_count <= w_cnt_new;
                        if (!s_axis.tlast) begin
                            r_buf <= w_buf_data;
                            if (w_ptr_next >= w_bw) begin
                                r_ptr     <= 8'd0;
                                r_after   <= ST_FILL;
                                r_state   <= ST_EMIT_DATA;
                                r_m_valid <= 1'b1;
                                r_m_last  <= 1'b0;
                            end else begin
                                r_ptr   <= w_ptr_next;
                                r_state <= ST_FILL;
                            end
                        end else if (w_fill >= w_bw) begin
                            // Message ends exactly on a block edge.
                            r_buf     <= w_buf_data;
                            r_after   <= ST_PAD_FULL;
                            r_state   <= ST_EMIT_DATA;
                            r_m_valid <= 1'b1;
                            r_m_last  <= 1'b0;
                        end else if (w_fill <= w_lim) begin
                            r_buf     <= w_buf_len;
                            r_state   <= ST_EMIT_FINAL;
                            r_m_valid <= 1'b1;
                            r_m_last  <= 1'b1;
                        end else begin
                            // Marker fits but the length does not.
                            r_buf     <= w_buf_mark;
                            r_after   <= ST_PAD_LEN;
                            r_state   <= ST_EMIT_DATA;
                            r_m_valid <= 1'b1;
                            r_m_last  <= 1'b0;
                        end
                    end
                end
                ST_EMIT_DATA: begin
                    if (m_axis.tready) begin
                        r_buf     <= '0;
                        r_ptr     <= 8'd0;
                        r_m_valid <= 1'b0;
                        r_state   <= r_after;
                    end
                end
                ST_PAD_FULL: begin
                    r_buf     <= w_pad_full;
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b1;
                    r_state   <= ST_EMIT_FINAL;
                end
                ST_PAD_LEN: begin
                    r_buf     <= w_pad_len;
                    r_m_valid <= 1'b1;
                    r_m_last  <= 1'b1;
                    r_state   <= ST_EMIT_FINAL;
                end
                ST_EMIT_FINAL: begin
                    if (m_axis.tready) begin
                        r_buf     <= '0;
                        r_ptr     <= 8'd0;
                        r_count   <= '0;
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sha2_padder_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha2_padder_multi
// Description : Directed self-checking bench for sha2_padder_multi. Uses a
//               64-bit input instance for most messages and a 512-bit input
//               instance for the single-beat full-block message.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha2_padder_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    logic sha_type;
    logic en2 = 1'b1;
    logic st2 = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sha2_padder_multi_if #(.DATA_WIDTH(64))   s_if ();
    sha2_padder_multi_if #(.DATA_WIDTH(1024)) m_if ();
    sha2_padder_multi_if #(.DATA_WIDTH(512))  s2_if ();
    sha2_padder_multi_if #(.DATA_WIDTH(1024)) m2_if ();

    sha2_padder_multi #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(1024), .LEN_WIDTH(64)) dut (
        .axis_aclk (clk),
        .axis_reset(rst),
        .sha_type  (sha_type),
        .en        (en),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    sha2_padder_multi #(.S_DATA_WIDTH(512), .M_DATA_WIDTH(1024), .LEN_WIDTH(64)) dut512 (
        .axis_aclk (clk),
        .axis_reset(rst),
        .sha_type  (st2),
        .en        (en2),
        .s_axis    (s2_if),
        .m_axis    (m2_if)
    );

    task automatic chk1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chkblk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int pos = -1;
        total++;
        for (int i = 127; i >= 0; i--) begin
            if (pos < 0 && obs[8*i +: 8] !== exp[8*i +: 8]) pos = i;
        end
        if (pos < 0) pos = 0;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: bits [%0d:%0d] got %h want %h", tag, 8*pos+7, 8*pos, obs[8*pos +: 8], exp[8*pos +: 8]);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        assert (n < 40) else begin
            bad++;
            $error("FAIL send_wait: waited %0d cycles want <40", n);
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [1023:0] exp, input logic exp_last);
        int n = 0;
        while (!m_if.tvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        assert (n < 40) else begin
            bad++;
            $error("FAIL %s_wait: waited %0d cycles want <40", tag, n);
        end
        chkblk({tag, "_data"}, m_if.tdata, exp);
        chk1({tag, "_last"}, 64'(m_if.tlast), 64'(exp_last));
        m_if.tready = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [1023:0] e_abc256;
    logic [1023:0] e_abc512;
    logic [1023:0] e;
    logic [63:0]   d;
    logic [511:0]  d2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_abc256 = '0;
        e_abc256[511:480] = 32'h61626380;
        e_abc256[63:0]    = 64'h18;
        e_abc512 = '0;
        e_abc512[1023:992] = 32'h61626380;
        e_abc512[127:0]    = 128'h18;

        rst = 1'b1; en = 1'b1; sha_type = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        s2_if.tvalid = 1'b0; s2_if.tdata = '0; s2_if.tkeep = '0; s2_if.tlast = 1'b0;
        m_if.tready = 1'b1; m2_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk1("rst_m_valid", 64'(m_if.tvalid), 64'd0);
        chk1("rst_m_last", 64'(m_if.tlast), 64'd0);
        chkblk("rst_m_data", m_if.tdata, '0);
        chk1("rst_s_ready", 64'(s_if.tready), 64'd0);

        // First cycle after release: ready follows en
        rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        chk1("idle_ready_en0", 64'(s_if.tready), 64'd0);
        en = 1'b1;
        #1;
        chk1("idle_ready_en1", 64'(s_if.tready), 64'd1);
        @(posedge clk); #1;

        // SHA-256 "abc"
        send(64'h636261, 8'h07, 1'b1);
        chk1("abc256_latency", 64'(m_if.tvalid), 64'd1);
        recv("abc256", e_abc256, 1'b1);
        chk1("b2b_ready", 64'(s_if.tready), 64'd1);

        // SHA-512 "abc"
        sha_type = 1'b1;
        send(64'h636261, 8'h07, 1'b1);
        recv("abc512", e_abc512, 1'b1);
        sha_type = 1'b0;

        // 56-byte message: sha_type and en change mid-message and are ignored
        for (int b = 0; b < 7; b++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8*b + k);
            send(d, 8'hFF, b == 6);
            if (b == 0) begin
                sha_type = 1'b1;
                en       = 1'b0;
            end
        end
        e = '0;
        for (int j = 0; j < 56; j++) e[511 - 8*j -: 8] = 8'(j);
        e[63:56] = 8'h80;
        recv("m56_blk1", e, 1'b0);
        e = '0;
        e[63:0] = 64'h1C0;
        recv("m56_blk2", e, 1'b1);
        sha_type = 1'b0;
        en       = 1'b1;

        // Empty message
        send(64'h0, 8'h00, 1'b1);
        e = '0;
        e[511:504] = 8'h80;
        recv("empty", e, 1'b1);

        // Backpressure: block held, input stalled
        m_if.tready = 1'b0;
        send(64'h636261, 8'h07, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk1("bp_valid", 64'(m_if.tvalid), 64'd1);
            chkblk("bp_hold", m_if.tdata, e_abc256);
            chk1("bp_s_ready", 64'(s_if.tready), 64'd0);
            @(posedge clk); #1;
        end
        m_if.tready = 1'b1;
        recv("bp", e_abc256, 1'b1);

        // Reset mid-message discards partial block and count
        send(64'h1111111111111111, 8'hFF, 1'b0);
        send(64'h2222222222222222, 8'hFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk1("midrst_m_valid", 64'(m_if.tvalid), 64'd0);
        chkblk("midrst_m_data", m_if.tdata, '0);
        chk1("midrst_s_ready", 64'(s_if.tready), 64'd0);
        rst = 1'b0;
        send(64'h636261, 8'h07, 1'b1);
        recv("rst_abc", e_abc256, 1'b1);

        // 64-byte message on the 512-bit input instance
        for (int k = 0; k < 64; k++) d2[8*k +: 8] = 8'(k + 1);
        s2_if.tdata  = d2;
        s2_if.tkeep  = '1;
        s2_if.tlast  = 1'b1;
        s2_if.tvalid = 1'b1;
        chk1("s512_ready", 64'(s2_if.tready), 64'd1);
        @(posedge clk); #1;
        s2_if.tvalid = 1'b0;
        s2_if.tlast  = 1'b0;
        e = '0;
        for (int j = 0; j < 64; j++) e[511 - 8*j -: 8] = 8'(j + 1);
        chk1("s512_blk1_valid", 64'(m2_if.tvalid), 64'd1);
        chkblk("s512_blk1_data", m2_if.tdata, e);
        chk1("s512_blk1_last", 64'(m2_if.tlast), 64'd0);
        @(posedge clk); #1;
        chk1("s512_pad_gap", 64'(m2_if.tvalid), 64'd0);
        @(posedge clk); #1;
        e = '0;
        e[511:504] = 8'h80;
        e[63:0]    = 64'h200;
        chk1("s512_blk2_valid", 64'(m2_if.tvalid), 64'd1);
        chkblk("s512_blk2_data", m2_if.tdata, e);
        chk1("s512_blk2_last", 64'(m2_if.tlast), 64'd1);
        @(posedge clk); #1;
        chk1("s512_done", 64'(m2_if.tvalid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
